// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file with trap sequencing.
//   Holds mstatus/mie/mip/mtvec/mscratch/mepc/mcause/mtval and the
//   mcycle/minstret counters. It arbitrates exceptions and interrupts,
//   requests traps from fetch via trap_request/trap_ack, and handles mret.
// Ports:
//   clk, reset (async, active low)
//   csr_write_enable, func3, csr_immediate, csr_address, csr_data_in -> CSR op
//   csr_data_out        combinational read data
//   irq_external/timer/software, irq_fast[NUM_FAST_IRQ-1:0]  level irqs
//   instr_retired       retire pulse for minstret
//   exception_valid/cause/tval, current_pc   trap source info
//   mret                return from trap
//   trap_request/trap_ack/trap_target        handshake with fetch
//   mepc_out            return address
// Optional feature: define CSR_VECTORED_MTVEC_EN for vectored interrupt mode
//   (mtvec[0]=1 -> interrupts go to base + 4*code).
module csr_trap_unit #(
    parameter int          NUM_FAST_IRQ  = 16,
    parameter int          COUNTER_WIDTH = 64,
    parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    csr_write_enable,
    input  logic [2:0]              func3,
    input  logic [4:0]              csr_immediate,
    input  logic [11:0]             csr_address,
    input  logic [31:0]             csr_data_in,
    output logic [31:0]             csr_data_out,
    input  logic                    irq_external,
    input  logic                    irq_timer,
    input  logic                    irq_software,
    input  logic [NUM_FAST_IRQ-1:0] irq_fast,
    input  logic                    instr_retired,
    input  logic                    exception_valid,
    input  logic [3:0]              exception_cause,
    input  logic [31:0]             exception_tval,
    input  logic [31:0]             current_pc,
    input  logic                    mret,
    output logic                    trap_request,
    input  logic                    trap_ack,
    output logic [31:0]             trap_target,
    output logic [31:0]             mepc_out
);
    localparam logic [11:0] A_MSTATUS = 12'h300, A_MISA = 12'h301, A_MIE = 12'h304,
                            A_MTVEC = 12'h305, A_MSTATUSH = 12'h310, A_MSCRATCH = 12'h340,
                            A_MEPC = 12'h341, A_MCAUSE = 12'h342, A_MTVAL = 12'h343,
                            A_MIP = 12'h344, A_MCYCLE = 12'hB00, A_MINSTRET = 12'hB02,
                            A_MCYCLEH = 12'hB80, A_MINSTRETH = 12'hB82,
                            A_CYCLE = 12'hC00, A_TIME = 12'hC01, A_INSTRET = 12'hC02,
                            A_CYCLEH = 12'hC80, A_TIMEH = 12'hC81, A_INSTRETH = 12'hC82,
                            A_MARCHID = 12'hF12, A_MIMPID = 12'hF13;
    localparam logic [31:0] FAST_MASK = ((32'h1 << NUM_FAST_IRQ) - 32'h1) << 16;
    localparam logic [31:0] MIE_MASK  = FAST_MASK | 32'h0000_0888;
`ifdef CSR_VECTORED_MTVEC_EN
    localparam logic [31:0] MTVEC_RST = RESET_MTVEC & 32'hFFFF_FFFD;
`else
    localparam logic [31:0] MTVEC_RST = RESET_MTVEC & 32'hFFFF_FFFC;
`endif

    typedef enum logic {S_IDLE, S_PEND} state_t;

    state_t                   state_q, state_d;
    logic                     st_mie_q, st_mie_d, st_mpie_q, st_mpie_d;
    logic [31:0]              mie_q, mie_d, mip_q, mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0]              mepc_q, mepc_d, mcause_q, mcause_d, mtval_q, mtval_d;
    logic [COUNTER_WIDTH-1:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic                     sh_int_q, sh_int_d;
    logic [4:0]               sh_code_q, sh_code_d;
    logic [31:0]              sh_tval_q, sh_tval_d, sh_pc_q, sh_pc_d;

    logic [31:0] irq_vec, irq_act, src, wdata, tgt;
    logic [63:0] mcycle_x, minstret_x;
    logic        csr_we, take, arb_int;
    logic [4:0]  arb_code;
    logic [31:0] arb_tval;

    assign mcycle_x   = 64'(mcycle_q);
    assign minstret_x = 64'(minstret_q);
    assign irq_act    = mie_q & mip_q;
    assign csr_we     = csr_write_enable && (func3[1:0] != 2'b00);
    assign src        = func3[2] ? {27'b0, csr_immediate} : csr_data_in;

    always_comb begin
        irq_vec = 32'h0;
        irq_vec[16 +: NUM_FAST_IRQ] = irq_fast;
        irq_vec[11] = irq_external;
        irq_vec[7]  = irq_timer;
        irq_vec[3]  = irq_software;
    end

    // Combinational read mux; the RS/RC write data is built from it.
    always_comb begin
        csr_data_out = 32'h0;
        case (csr_address)
            A_MSTATUS:                csr_data_out = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
            A_MISA:                   csr_data_out = 32'h4000_0100;
            A_MIE:                    csr_data_out = mie_q;
            A_MTVEC:                  csr_data_out = mtvec_q;
            A_MSTATUSH:               csr_data_out = 32'h0;
            A_MSCRATCH:               csr_data_out = mscratch_q;
            A_MEPC:                   csr_data_out = mepc_q;
            A_MCAUSE:                 csr_data_out = mcause_q;
            A_MTVAL:                  csr_data_out = mtval_q;
            A_MIP:                    csr_data_out = mip_q;
            A_MCYCLE, A_CYCLE, A_TIME:    csr_data_out = mcycle_x[31:0];
            A_MCYCLEH, A_CYCLEH, A_TIMEH: csr_data_out = mcycle_x[63:32];
            A_MINSTRET, A_INSTRET:    csr_data_out = minstret_x[31:0];
            A_MINSTRETH, A_INSTRETH:  csr_data_out = minstret_x[63:32];
            A_MARCHID, A_MIMPID:      csr_data_out = 32'h0;
            default:                  csr_data_out = 32'h0;
        endcase
    end

    always_comb begin
        case (func3[1:0])
            2'b01:   wdata = src;
            2'b10:   wdata = csr_data_out | src;
            2'b11:   wdata = csr_data_out & ~src;
            default: wdata = csr_data_out;
        endcase
    end

    // Exception beats all interrupts; fast irqs beat the standard ones.
    always_comb begin
        take     = 1'b0;
        arb_int  = 1'b0;
        arb_code = 5'd0;
        arb_tval = 32'h0;
        if (exception_valid) begin
            take     = 1'b1;
            arb_code = {1'b0, exception_cause};
            arb_tval = exception_tval;
        end else if ((irq_act != 32'h0) && st_mie_q) begin
            take    = 1'b1;
            arb_int = 1'b1;
            if (irq_act[31:16] != 16'h0) begin
                for (int i = NUM_FAST_IRQ - 1; i >= 0; i--)
                    if (irq_act[16+i]) arb_code = 5'(16 + i);
            end else if (irq_act[11]) arb_code = 5'd11;
            else if (irq_act[3])      arb_code = 5'd3;
            else                      arb_code = 5'd7;
        end
    end

    always_comb begin
        state_d    = state_q;
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mcycle_d   = mcycle_q + COUNTER_WIDTH'(1);
        minstret_d = instr_retired ? minstret_q + COUNTER_WIDTH'(1) : minstret_q;
        sh_int_d   = sh_int_q;
        sh_code_d  = sh_code_q;
        sh_tval_d  = sh_tval_q;
        sh_pc_d    = sh_pc_q;

        if (csr_we) begin
            case (csr_address)
                A_MSTATUS:   begin st_mie_d = wdata[3]; st_mpie_d = wdata[7]; end
                A_MIE:       mie_d = wdata & MIE_MASK;
`ifdef CSR_VECTORED_MTVEC_EN
                A_MTVEC:     mtvec_d = {wdata[31:2], 1'b0, wdata[0]};
`else
                A_MTVEC:     mtvec_d = {wdata[31:2], 2'b00};
`endif
                A_MSCRATCH:  mscratch_d = wdata;
                A_MEPC:      mepc_d = {wdata[31:2], 2'b00};
                A_MCAUSE:    mcause_d = wdata;
                A_MTVAL:     mtval_d = wdata;
                // A written counter takes the new half and skips this cycle's increment.
                A_MCYCLE:    mcycle_d = {mcycle_q[COUNTER_WIDTH-1:32], wdata};
                A_MCYCLEH:   mcycle_d = COUNTER_WIDTH'({wdata, mcycle_q[31:0]});
                A_MINSTRET:  minstret_d = {minstret_q[COUNTER_WIDTH-1:32], wdata};
                A_MINSTRETH: minstret_d = COUNTER_WIDTH'({wdata, minstret_q[31:0]});
                default: ;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (take) begin
                    sh_int_d  = arb_int;
                    sh_code_d = arb_code;
                    sh_tval_d = arb_tval;
                    sh_pc_d   = current_pc;
                    state_d   = S_PEND;
                end else if (mret) begin
                    st_mie_d  = st_mpie_q;
                    st_mpie_d = 1'b1;
                end
            end
            S_PEND: begin
                // Commit overrides any same-cycle CSR write to these registers.
                if (trap_ack) begin
                    mepc_d    = sh_pc_q;
                    mcause_d  = {sh_int_q, 26'b0, sh_code_q};
                    mtval_d   = sh_tval_q;
                    st_mpie_d = st_mie_q;
                    st_mie_d  = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b1;
            mie_q      <= 32'h0;
            mip_q      <= 32'h0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mtval_q    <= 32'h0;
            mcycle_q   <= '0;
            minstret_q <= '0;
            sh_int_q   <= 1'b0;
            sh_code_q  <= 5'd0;
            sh_tval_q  <= 32'h0;
            sh_pc_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mie_q      <= mie_d;
            mip_q      <= irq_vec;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
            sh_int_q   <= sh_int_d;
            sh_code_q  <= sh_code_d;
            sh_tval_q  <= sh_tval_d;
            sh_pc_q    <= sh_pc_d;
        end
    end

    always_comb begin
        tgt = {mtvec_q[31:2], 2'b00};
`ifdef CSR_VECTORED_MTVEC_EN
        if (mtvec_q[0] && sh_int_q) tgt = {mtvec_q[31:2], 2'b00} + {25'b0, sh_code_q, 2'b00};
`endif
    end

    assign trap_request = (state_q == S_PEND);
    assign trap_target  = trap_request ? tgt : 32'h0;
    assign mepc_out     = mepc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
module tb_csr_trap_unit;
    logic        clk = 1'b0, reset = 1'b0;
    logic        csr_write_enable = 1'b0;
    logic [2:0]  func3 = 3'b0;
    logic [4:0]  csr_immediate = 5'b0;
    logic [11:0] csr_address = 12'h0;
    logic [31:0] csr_data_in = 32'h0, csr_data_out;
    logic        irq_external = 1'b0, irq_timer = 1'b0, irq_software = 1'b0;
    logic [15:0] irq_fast = 16'h0;
    logic        instr_retired = 1'b0, exception_valid = 1'b0;
    logic [3:0]  exception_cause = 4'h0;
    logic [31:0] exception_tval = 32'h0, current_pc = 32'h0;
    logic        mret = 1'b0, trap_request, trap_ack = 1'b0;
    logic [31:0] trap_target, mepc_out;

    int n_chk = 0, n_pass = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    localparam logic [2:0] RW = 3'b001, RS = 3'b010, RC = 3'b011, RSI = 3'b110;
`ifdef CSR_VECTORED_MTVEC_EN
    localparam logic [31:0] MTVEC_RB = 32'h0000_0401, FAST_TGT = 32'h0000_0448;
`else
    localparam logic [31:0] MTVEC_RB = 32'h0000_0400, FAST_TGT = 32'h0000_0400;
`endif

    csr_trap_unit #(.NUM_FAST_IRQ(16), .COUNTER_WIDTH(40), .RESET_MTVEC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset), .csr_write_enable(csr_write_enable), .func3(func3),
        .csr_immediate(csr_immediate), .csr_address(csr_address), .csr_data_in(csr_data_in),
        .csr_data_out(csr_data_out), .irq_external(irq_external), .irq_timer(irq_timer),
        .irq_software(irq_software), .irq_fast(irq_fast), .instr_retired(instr_retired),
        .exception_valid(exception_valid), .exception_cause(exception_cause),
        .exception_tval(exception_tval), .current_pc(current_pc), .mret(mret),
        .trap_request(trap_request), .trap_ack(trap_ack), .trap_target(trap_target),
        .mepc_out(mepc_out));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [2:0] f3, input logic [31:0] d);
        csr_address = a; func3 = f3; csr_data_in = d; csr_immediate = d[4:0];
        csr_write_enable = 1'b1;
        cyc();
        csr_write_enable = 1'b0;
    endtask

    // Expected value is queued first, then popped when the DUT output is sampled.
    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        exp_q.push_back(exp); tag_q.push_back(tag);
        csr_address = a; #1;
        chk(tag_q.pop_front(), csr_data_out, exp_q.pop_front());
    endtask

    task automatic wait_trap(input string tag, input logic [31:0] exp_tgt);
        bit seen = 1'b0;
        exp_q.push_back(exp_tgt); tag_q.push_back(tag);
        for (int k = 0; k < 6; k++) begin
            if (trap_request) begin seen = 1'b1; break; end
            cyc();
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 32'(trap_request), 32'h1);
            void'(exp_q.pop_front()); void'(tag_q.pop_front());
        end else chk(tag_q.pop_front(), trap_target, exp_q.pop_front());
    endtask

    task automatic ack();
        trap_ack = 1'b1; cyc(); trap_ack = 1'b0;
        chk("req_fall", 32'(trap_request), 32'h0);
    endtask

    initial begin
        repeat (2) cyc();
        chk("rst_req", 32'(trap_request), 32'h0);
        chk("rst_tgt", trap_target, 32'h0);
        chk("rst_mepc", mepc_out, 32'h0);
        reset = 1'b1;
        cyc();
        rd("mstatus_rst", 12'h300, 32'h0000_1880);
        rd("misa", 12'h301, 32'h4000_0100);
        rd("mtvec_rst", 12'h305, 32'h0000_0100);
        rd("mie_rst", 12'h304, 32'h0);
        cyc();
        csr_wr(12'h344, RW, 32'hFFFF_FFFF);
        rd("mip_ro", 12'h344, 32'h0);
        rd("marchid", 12'hF12, 32'h0);

        // External interrupt, dropped before ack: still taken.
        csr_wr(12'h305, RW, 32'h0000_0400);
        csr_wr(12'h304, RS, 32'h0000_0800);
        csr_wr(12'h300, RSI, 32'h8);
        current_pc = 32'h0000_0120; irq_external = 1'b1;
        wait_trap("ext_tgt", 32'h0000_0400);
        irq_external = 1'b0;
        cyc(); cyc();
        chk("ext_hold", 32'(trap_request), 32'h1);
        ack();
        rd("ext_mcause", 12'h342, 32'h8000_000B);
        rd("ext_mepc", 12'h341, 32'h0000_0120);
        rd("ext_mstatus", 12'h300, 32'h0000_1880);
        rd("ext_mtval", 12'h343, 32'h0);
        chk("ext_mepc_out", mepc_out, 32'h0000_0120);

        // mret restores MIE from MPIE.
        cyc();
        mret = 1'b1; cyc(); mret = 1'b0;
        rd("mret_mstatus", 12'h300, 32'h0000_1888);

        // Fast irq 2 vs timer; a later exception must not change the latched cause.
        cyc();
        csr_wr(12'h305, RW, 32'h0000_0401);
        rd("mtvec_b0", 12'h305, MTVEC_RB);
        csr_wr(12'h304, RS, 32'h0004_0080);
        current_pc = 32'h0000_0300; irq_fast = 16'h0004; irq_timer = 1'b1;
        wait_trap("fast_tgt", FAST_TGT);
        exception_valid = 1'b1; exception_cause = 4'd5;
        cyc();
        exception_valid = 1'b0;
        chk("fast_tgt_hold", trap_target, FAST_TGT);
        ack();
        irq_fast = 16'h0; irq_timer = 1'b0;
        rd("fast_mcause", 12'h342, 32'h8000_0012);
        rd("fast_mtval", 12'h343, 32'h0);
        rd("fast_mepc", 12'h341, 32'h0000_0300);

        // Exception concurrent with enabled timer irq.
        cyc();
        irq_timer = 1'b1;
        cyc();
        csr_wr(12'h300, RSI, 32'h8);
        exception_valid = 1'b1; exception_cause = 4'd2;
        exception_tval = 32'hDEAD_BEEF; current_pc = 32'h0000_0200;
        cyc();
        exception_valid = 1'b0;
        wait_trap("exc_tgt", 32'h0000_0400);
        ack();
        irq_timer = 1'b0;
        rd("exc_mcause", 12'h342, 32'h0000_0002);
        rd("exc_mtval", 12'h343, 32'hDEAD_BEEF);
        rd("exc_mepc", 12'h341, 32'h0000_0200);

        // Counters (40-bit): carry into high half, high bits clipped, wrap.
        cyc();
        csr_wr(12'hB80, RW, 32'h0);
        csr_wr(12'hB00, RW, 32'hFFFF_FFFF);
        cyc();
        rd("mcycleh_carry", 12'hB80, 32'h1);
        rd("mcycle_carry", 12'hB00, 32'h0);
        rd("cycleh_alias", 12'hC80, 32'h1);
        cyc();
        csr_wr(12'hB80, RW, 32'hFFFF_FFFF);
        rd("mcycleh_clip", 12'hB80, 32'h0000_00FF);
        cyc();
        csr_wr(12'hB00, RW, 32'hFFFF_FFFF);
        cyc();
        rd("mcycleh_wrap", 12'hB80, 32'h0);
        rd("mcycle_wrap", 12'hB00, 32'h0);
        cyc();
        instr_retired = 1'b1;
        csr_wr(12'hB02, RW, 32'h5);
        cyc(); cyc();
        instr_retired = 1'b0;
        rd("minstret", 12'hB02, 32'h7);
        rd("instret_alias", 12'hC02, 32'h7);
        rd("minstreth", 12'hB82, 32'h0);

        // Scratch RC and mepc alignment.
        cyc();
        csr_wr(12'h340, RW, 32'hF0F0_F0F0);
        csr_wr(12'h340, RC, 32'h0000_00F0);
        rd("mscratch_rc", 12'h340, 32'hF0F0_F000);
        cyc();
        csr_wr(12'h341, RW, 32'h1234_5677);
        rd("mepc_align", 12'h341, 32'h1234_5674);
        chk("mepc_out", mepc_out, 32'h1234_5674);

        // Asynchronous reset while a trap is pending.
        cyc();
        irq_external = 1'b1;
        csr_wr(12'h300, RSI, 32'h8);
        wait_trap("rst_trap_tgt", 32'h0000_0400);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_req", 32'(trap_request), 32'h0);
        chk("async_rst_tgt", trap_target, 32'h0);
        irq_external = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        cyc();
        rd("mtvec_after_rst", 12'h305, 32'h0000_0100);
        rd("mstatus_after_rst", 12'h300, 32'h0000_1880);
        rd("mie_after_rst", 12'h304, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
